// File: rtl/sound_pkg.sv
// ============================================================================
// sound_pkg : shared types and note tables for the sound sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic {
        SEQ_EAT  = 1'b0,
        SEQ_OVER = 1'b1
    } seq_t;

    localparam int EAT_LEN  = 2;
    localparam int OVER_LEN = 4;
    localparam int MAX_PERIOD = 255;

    localparam logic [7:0] EAT_PER  [EAT_LEN]  = '{8'd190, 8'd127};
    localparam logic [7:0] OVER_PER [OVER_LEN] = '{8'd255, 8'd214, 8'd190, 8'd160};

    function automatic logic [7:0] note_period(input seq_t s, input logic [1:0] i);
        if (s == SEQ_OVER) begin
            return OVER_PER[i];
        end
        return EAT_PER[i[0]];
    endfunction

    function automatic logic [1:0] last_idx(input seq_t s);
        return (s == SEQ_OVER) ? 2'(OVER_LEN - 1) : 2'(EAT_LEN - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sound_sequencer_tone_gen.sv
// ============================================================================
// tone_gen : phase counter producing P cycles high then one cycle low
// Revision : 1.0
// ============================================================================
`default_nettype none

module tone_gen #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [PER_W-1:0] period,
    output logic             gate
);

    logic [PER_W-1:0] phase;
    logic [PER_W-1:0] phase_nxt;

    always_comb begin
        phase_nxt = (phase == period) ? '0 : phase + PER_W'(1);
    end

    // gate is computed from the phase being loaded so it stays aligned with it
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase <= '0;
            gate  <= 1'b0;
        end else if (restart) begin
            phase <= '0;
            gate  <= (period != '0);
        end else begin
            phase <= phase_nxt;
            gate  <= (phase_nxt != period);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sound_sequencer.sv
// ============================================================================
// sound_sequencer : plays eat / game-over note sequences as a DAC gate
// Revision : 1.0   (optional SOUND_MUTE_EN adds the mute input)
// ============================================================================
`default_nettype none

module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NOTE_CYC = 2_500_000,
    parameter int GAP_CYC  = 250_000,
    parameter int PER_W    = 16,
    parameter int DUR_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eat_evt,
    input  logic       over_evt,
`ifdef SOUND_MUTE_EN
    input  logic       mute,
`endif
    output logic       at_max,
    output logic       busy,
    output logic [1:0] note_idx
);

    localparam int DUR_MAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;

    generate
        if (DUR_MAX >= (2 ** DUR_W)) begin : g_dur_chk
            $error("DUR_W too narrow for NOTE_CYC/GAP_CYC");
        end
        if (MAX_PERIOD >= (2 ** PER_W)) begin : g_per_chk
            $error("PER_W too narrow for note period table");
        end
    endgenerate

    state_t           state, state_nxt;
    seq_t             seq, seq_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [DUR_W-1:0] dur, dur_nxt;
    logic             restart;
    logic             tone_en;
    logic             tone_gate;
    logic [PER_W-1:0] period;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            seq   <= SEQ_EAT;
            idx   <= 2'd0;
            dur   <= '0;
        end else begin
            state <= state_nxt;
            seq   <= seq_nxt;
            idx   <= idx_nxt;
            dur   <= dur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        seq_nxt   = seq;
        idx_nxt   = idx;
        dur_nxt   = dur;
        restart   = 1'b0;
        if (over_evt) begin
            state_nxt = ST_NOTE;
            seq_nxt   = SEQ_OVER;
            idx_nxt   = 2'd0;
            dur_nxt   = '0;
            restart   = 1'b1;
        end else if (eat_evt && (state == ST_IDLE || seq == SEQ_EAT)) begin
            state_nxt = ST_NOTE;
            seq_nxt   = SEQ_EAT;
            idx_nxt   = 2'd0;
            dur_nxt   = '0;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_NOTE: begin
                    if (dur == DUR_W'(NOTE_CYC - 1)) begin
                        dur_nxt = '0;
                        if (idx == last_idx(seq)) begin
                            state_nxt = ST_IDLE;
                            idx_nxt   = 2'd0;
                        end else begin
                            state_nxt = ST_GAP;
                        end
                    end else begin
                        dur_nxt = dur + DUR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (dur == DUR_W'(GAP_CYC - 1)) begin
                        state_nxt = ST_NOTE;
                        idx_nxt   = idx + 2'd1;
                        dur_nxt   = '0;
                        restart   = 1'b1;
                    end else begin
                        dur_nxt = dur + DUR_W'(1);
                    end
                end
                default: begin
                    dur_nxt = '0;
                end
            endcase
        end
    end

    // Tone control looks at the next state so the gate rises on the same edge as busy
    always_comb begin
        tone_en  = (state_nxt == ST_NOTE);
        period   = PER_W'(note_period(seq_nxt, idx_nxt));
        busy     = (state != ST_IDLE);
        note_idx = idx;
    end

    tone_gen #(
        .PER_W (PER_W)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .restart (restart),
        .period  (period),
        .gate    (tone_gate)
    );

`ifdef SOUND_MUTE_EN
    logic mute_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mute_q <= 1'b0;
        end else begin
            mute_q <= mute;
        end
    end

    assign at_max = tone_gate & ~mute_q;
`else
    assign at_max = tone_gate;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sound_sequencer.sv
// ============================================================================
// tb_sound_sequencer : directed self-checking bench, NOTE_CYC=600 GAP_CYC=4
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eat_evt = 1'b0;
    logic       over_evt = 1'b0;
    logic       mute = 1'b0;
    logic       at_max;
    logic       busy;
    logic [1:0] note_idx;

    int checks = 0;
    int errors = 0;
    int k = 0;      // cycles elapsed since the last event was sampled
    int cnt;

    always #5 clk = ~clk;

    sound_sequencer #(
        .NOTE_CYC (600),
        .GAP_CYC  (4),
        .PER_W    (16),
        .DUR_W    (24)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .eat_evt  (eat_evt),
        .over_evt (over_evt),
`ifdef SOUND_MUTE_EN
        .mute     (mute),
`endif
        .at_max   (at_max),
        .busy     (busy),
        .note_idx (note_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int target);
        while (k < target) tick();
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            c += int'(at_max);
        end
    endtask

    task automatic fire(input logic e, input logic o);
        eat_evt  = e;
        over_evt = o;
        tick();
        eat_evt  = 1'b0;
        over_evt = 1'b0;
        k = 1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_at_max", 32'(at_max), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_idx", 32'(note_idx), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // eat sequence: 190 high / 1 low, then 127 high / 1 low
        fire(1'b1, 1'b0);
        check("eat_start_gate", 32'(at_max), 1);
        check("eat_start_busy", 32'(busy), 1);
        check("eat_start_idx", 32'(note_idx), 0);
        count_high(189, cnt);
        check("eat_n0_high", 32'(cnt), 189);
        tick();
        check("eat_n0_low", 32'(at_max), 0);
        tick();
        check("eat_n0_rehigh", 32'(at_max), 1);
        goto(600);
        check("eat_n0_end_busy", 32'(busy), 1);
        count_high(4, cnt);
        check("eat_gap_silent", 32'(cnt), 0);
        check("eat_gap_busy", 32'(busy), 1);
        tick();
        check("eat_n1_idx", 32'(note_idx), 1);
        check("eat_n1_gate", 32'(at_max), 1);
        count_high(126, cnt);
        check("eat_n1_high", 32'(cnt), 126);
        tick();
        check("eat_n1_low", 32'(at_max), 0);
        tick();
        check("eat_n1_rehigh", 32'(at_max), 1);
        goto(1204);
        check("eat_last_busy", 32'(busy), 1);
        tick();
        check("eat_done_busy", 32'(busy), 0);
        check("eat_done_gate", 32'(at_max), 0);
        check("eat_done_idx", 32'(note_idx), 0);
        for (int i = 0; i < 5; i++) tick();

        // simultaneous events: over wins
        fire(1'b1, 1'b1);
        check("sim_idx0", 32'(note_idx), 0);
        count_high(254, cnt);
        check("sim_n0_high", 32'(cnt), 254);
        tick();
        check("sim_n0_low", 32'(at_max), 0);
        goto(605);
        check("sim_idx1", 32'(note_idx), 1);
        goto(1209);
        check("sim_idx2", 32'(note_idx), 2);
        goto(1813);
        check("sim_idx3", 32'(note_idx), 3);
        goto(2412);
        check("sim_last_busy", 32'(busy), 1);
        tick();
        check("sim_done_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) tick();

        // preemption: over during eat note 1
        fire(1'b1, 1'b0);
        goto(700);
        check("pre_eat_idx", 32'(note_idx), 1);
        fire(1'b0, 1'b1);
        check("pre_idx", 32'(note_idx), 0);
        check("pre_gate", 32'(at_max), 1);
        goto(255);
        check("pre_p255_high", 32'(at_max), 1);
        tick();
        check("pre_p255_low", 32'(at_max), 0);
        goto(300);
        eat_evt = 1'b1;
        tick();
        eat_evt = 1'b0;
        check("ign_gate", 32'(at_max), 1);
        check("ign_idx", 32'(note_idx), 0);
        goto(512);
        check("ign_phase_low", 32'(at_max), 0);
        goto(605);
        check("ign_idx1", 32'(note_idx), 1);

        // reset during over note 2 with a coincident eat event
        goto(1300);
        check("rstm_idx2", 32'(note_idx), 2);
        rst     = 1'b1;
        eat_evt = 1'b1;
        tick();
        rst     = 1'b0;
        eat_evt = 1'b0;
        check("rstm_gate", 32'(at_max), 0);
        check("rstm_busy", 32'(busy), 0);
        check("rstm_idx", 32'(note_idx), 0);
        count_high(20, cnt);
        check("rstm_idle_gate", 32'(cnt), 0);
        check("rstm_idle_busy", 32'(busy), 0);

`ifdef SOUND_MUTE_EN
        fire(1'b1, 1'b0);
        goto(50);
        mute = 1'b1;
        tick();
        check("mute_gate", 32'(at_max), 0);
        check("mute_busy", 32'(busy), 1);
        goto(150);
        check("mute_hold", 32'(at_max), 0);
        goto(190);
        mute = 1'b0;
        tick();
        check("unmute_low", 32'(at_max), 0);
        tick();
        check("unmute_high", 32'(at_max), 1);
        check("unmute_idx", 32'(note_idx), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sound_sequencer.md
# sound_sequencer

Generates the gate waveform for the game's sound path. On a one-cycle event pulse (snake eats food, game over) it plays a fixed short note sequence by driving `at_max` to the DAC counter directly downstream. Each note appears as a periodic high run: the counter ramps while the gate is high and clears on each one-cycle low, so the note period sets the ramp period and therefore the pitch.

## Interface
- `NOTE_CYC`, 2_500_000: cycles each note lasts
- `GAP_CYC`, 250_000: silent cycles between consecutive notes
- `PER_W`, 16: width of the tone period counter
- `DUR_W`, 24: width of the note/gap duration counter; must hold `max(NOTE_CYC, GAP_CYC)`
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `eat_evt`  in  1  one-cycle pulse; request eat sequence
- `over_evt`  in  1  one-cycle pulse; request game-over sequence
- `mute`  in  1  force gate low (present only with `SOUND_MUTE_EN`)
- `at_max`  out  1  gate to DAC counter; high = count, low = clear
- `busy`  out  1  sequence in progress
- `note_idx`  out  2  index of the current note within the sequence

## Operation
- Sequences (periods in cycles, in order):
  - eat: 190, 127 (2 notes)
  - over: 255, 214, 190, 160 (4 notes)
- FSM states: IDLE, NOTE, GAP.
  - IDLE → NOTE on an event; `note_idx`=0; tone phase counter cleared.
  - NOTE → GAP after `NOTE_CYC` cycles if more notes remain; otherwise NOTE → IDLE.
  - GAP → NOTE after `GAP_CYC` cycles; `note_idx`+1; phase cleared.
- Tone generation in NOTE:
  - Phase counter runs 0..P, then wraps to 0.
  - `at_max`=1 while phase < P; `at_max`=0 when phase == P.
  - Result: high for P cycles, low for 1 cycle, period P+1.
- `at_max`=0 in IDLE and GAP.
- `busy`=1 in NOTE and GAP.
- Priority rules:
  - `over_evt` and `eat_evt` in the same cycle → over wins.
  - `over_evt` during any sequence → restart as over at note 0.
  - `eat_evt` during an eat sequence → restart eat at note 0.
  - `eat_evt` during an over sequence → ignored.
- Period arithmetic is unsigned `PER_W`-bit; the package constants must be < 2^PER_W.
- `DUR_W` overflow is a parameter error; flag it with an elaboration assertion.

## Timing
- Reset values: state IDLE, `at_max`=0, `busy`=0, `note_idx`=0, all counters 0.
- `rst` asserted mid-sequence:
  - Next edge returns to IDLE with the outputs above.
  - Any event pulse in the same cycle as `rst` is discarded.
- Latency: event sampled at edge k → `busy`=1 and `at_max`=1 from edge k+1.
- NOTE lasts exactly `NOTE_CYC` cycles; GAP lasts exactly `GAP_CYC` cycles.
- A note is cut at its duration boundary regardless of tone phase.
- `at_max` is registered; no combinational path from inputs to outputs.
- A restart takes effect at the next edge: phase and duration clear, `note_idx`=0.

## Configuration
- `SOUND_MUTE_EN` defined:
  - `mute` port exists.
  - While `mute`=1, `at_max` is forced 0 (registered, one-cycle latency).
  - FSM, counters, `busy` and `note_idx` advance unchanged.
- Undefined: no `mute` port; gate never forced.

## Structure
- `sound_pkg` holds:
  - state enum (IDLE, NOTE, GAP)
  - sequence-select enum (EAT, OVER)
  - note period constant arrays and sequence lengths
- Sub-module `tone_gen`:
  - Inputs: `clk`, `rst`, `en`, `restart`, `period[PER_W]`.
  - Output: registered `gate`.
  - Contains the phase counter and the P-high / 1-low pattern.
- Sequencer owns the FSM, duration counter and note index.

## Test plan
All scenarios use `NOTE_CYC`=600, `GAP_CYC`=4.
- Eat sequence: `eat_evt` at cycle 10 → `at_max` high cycles 11–200, low at 201, high again from 202; after 600 cycles, 4 low cycles; note 1 shows 127 high + 1 low; `busy` falls after cycle 1214.
- Simultaneous events: `eat_evt` and `over_evt` in the same cycle → first note period 255; `note_idx` steps 0..3; sequence ends after 4·600+3·4 cycles.
- Preemption: `over_evt` during eat note 1 → next cycle `note_idx`=0, period 255. Then `eat_evt` during over → no change in `at_max` or `note_idx`.
- Reset mid-note: `rst` pulsed during over note 2, with `eat_evt` in the same cycle → next edge `at_max`=0, `busy`=0, `note_idx`=0; stays idle.
- Mute (`SOUND_MUTE_EN`): `mute`=1 during eat note 0 → `at_max`=0 one cycle later, `busy` stays 1. Release `mute` → gate resumes at the phase-consistent value.
